// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg
//   Shared constants for the ID/EX pipeline register:
//   default widths, reset polarity, the NOP bubble encodings driven
//   onto the EX payload when no instruction is present, and the
//   occupancy state type of the elastic register.
package id_ex_pipe_pkg;

    // Default widths
    localparam int unsigned RegBus_W   = 32;
    localparam int unsigned RegAddr_W  = 5;
    localparam int unsigned AluOp_W    = 8;
    localparam int unsigned AluSel_W   = 3;

    // Reset polarity
    localparam logic RstEnable     = 1'b1;
    localparam logic RstDisable    = 1'b0;

    // Write-back control
    localparam logic WriteEnable   = 1'b1;
    localparam logic WriteDisable  = 1'b0;

    // NOP bubble encodings
    localparam logic [AluOp_W-1:0]   EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [AluSel_W-1:0]  EXE_RES_NOP = 3'b000;
    localparam logic [RegBus_W-1:0]  ZeroWord    = 32'h0000_0000;
    localparam logic [RegAddr_W-1:0] NOPRegAddr  = 5'b00000;

    // Occupancy of the two-entry elastic register
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/id_ex_pipe_slot.sv
// pipe_slot
//   One storage entry of the ID/EX elastic register: a valid bit plus
//   the full instruction payload. clear (or reset) empties the entry
//   and parks the payload at the NOP bubble; load captures new payload
//   and marks the entry valid. clear wins over load.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   clear               empty the entry
//   load                capture load_* and set valid
//   load_*              incoming payload
//   valid               entry holds an instruction
//   aluop..wreg_enable  held payload
module pipe_slot
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned REG_W    = RegBus_W,
    parameter int unsigned ADDR_W   = RegAddr_W,
    parameter int unsigned ALUOP_W  = AluOp_W,
    parameter int unsigned ALUSEL_W = AluSel_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [ALUOP_W-1:0]  load_aluop,
    input  logic [ALUSEL_W-1:0] load_alusel,
    input  logic [REG_W-1:0]    load_reg1,
    input  logic [REG_W-1:0]    load_reg2,
    input  logic [ADDR_W-1:0]   load_wreg_addr,
    input  logic                load_wreg_enable,
    output logic                valid,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [ALUSEL_W-1:0] alusel,
    output logic [REG_W-1:0]    reg1,
    output logic [REG_W-1:0]    reg2,
    output logic [ADDR_W-1:0]   wreg_addr,
    output logic                wreg_enable
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear) begin
            valid       <= 1'b0;
            aluop       <= ALUOP_W'(EXE_NOP_OP);
            alusel      <= ALUSEL_W'(EXE_RES_NOP);
            reg1        <= REG_W'(ZeroWord);
            reg2        <= REG_W'(ZeroWord);
            wreg_addr   <= ADDR_W'(NOPRegAddr);
            wreg_enable <= WriteDisable;
        end else if (load) begin
            valid       <= 1'b1;
            aluop       <= load_aluop;
            alusel      <= load_alusel;
            reg1        <= load_reg1;
            reg2        <= load_reg2;
            wreg_addr   <= load_wreg_addr;
            wreg_enable <= load_wreg_enable;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe
//   Two-entry elastic ID/EX pipeline register. The main slot drives the
//   EX payload; the skid slot absorbs one extra instruction so id_ready
//   can be a flop rather than a combinational function of ex_ready.
//   Strict FIFO order, 1-cycle latency, one instruction per cycle while
//   EX keeps ex_ready high. flush empties both slots on the next edge.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                discard all held entries
//   id_valid / id_ready  upstream handshake (id_ready registered)
//   id_*                 incoming payload
//   ex_valid / ex_ready  downstream handshake
//   ex_*                 payload to EX (NOP bubble when ex_valid = 0)
//   occupancy            entries held, 0..2
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned REG_W    = RegBus_W,
    parameter int unsigned ADDR_W   = RegAddr_W,
    parameter int unsigned ALUOP_W  = AluOp_W,
    parameter int unsigned ALUSEL_W = AluSel_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [REG_W-1:0]    id_reg1,
    input  logic [REG_W-1:0]    id_reg2,
    input  logic [ADDR_W-1:0]   id_wreg_addr,
    input  logic                id_wreg_enable,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [REG_W-1:0]    ex_reg1,
    output logic [REG_W-1:0]    ex_reg2,
    output logic [ADDR_W-1:0]   ex_wreg_addr,
    output logic                ex_wreg_enable,
    output logic [1:0]          occupancy
);

    pipe_state_t state, next_state;
    logic        ready_q;

    logic push, pop;

    // Slot controls
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;

    // Slot contents
    logic                main_valid, skid_valid;
    logic [ALUOP_W-1:0]  main_aluop, skid_aluop, main_d_aluop;
    logic [ALUSEL_W-1:0] main_alusel, skid_alusel, main_d_alusel;
    logic [REG_W-1:0]    main_reg1, skid_reg1, main_d_reg1;
    logic [REG_W-1:0]    main_reg2, skid_reg2, main_d_reg2;
    logic [ADDR_W-1:0]   main_wreg_addr, skid_wreg_addr, main_d_wreg_addr;
    logic                main_wreg_enable, skid_wreg_enable, main_d_wreg_enable;

    assign id_ready = ready_q;
    assign ex_valid = (state != ST_EMPTY);
    assign push     = id_valid && ready_q;
    assign pop      = ex_valid && ex_ready;

    // State register; id_ready is precomputed from the next state so it
    // never depends combinationally on ex_ready.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != ST_TWO);
        end
    end

    // Next state and slot steering
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            next_state = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        next_state = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_load  = 1'b1;
                    end else if (push) begin
                        next_state = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (pop) begin
                        next_state = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    // id_ready is low here, so only a pop can occur
                    if (pop && skid_valid) begin
                        next_state     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Main slot source: the skid entry when draining TWO, else ID
    always_comb begin
        main_d_aluop       = id_aluop;
        main_d_alusel      = id_alusel;
        main_d_reg1        = id_reg1;
        main_d_reg2        = id_reg2;
        main_d_wreg_addr   = id_wreg_addr;
        main_d_wreg_enable = id_wreg_enable;
        if (main_from_skid) begin
            main_d_aluop       = skid_aluop;
            main_d_alusel      = skid_alusel;
            main_d_reg1        = skid_reg1;
            main_d_reg2        = skid_reg2;
            main_d_wreg_addr   = skid_wreg_addr;
            main_d_wreg_enable = skid_wreg_enable;
        end
    end

    pipe_slot #(
        .REG_W    (REG_W),
        .ADDR_W   (ADDR_W),
        .ALUOP_W  (ALUOP_W),
        .ALUSEL_W (ALUSEL_W)
    ) u_main (
        .clk              (clk),
        .rst              (rst),
        .clear            (main_clear),
        .load             (main_load),
        .load_aluop       (main_d_aluop),
        .load_alusel      (main_d_alusel),
        .load_reg1        (main_d_reg1),
        .load_reg2        (main_d_reg2),
        .load_wreg_addr   (main_d_wreg_addr),
        .load_wreg_enable (main_d_wreg_enable),
        .valid            (main_valid),
        .aluop            (main_aluop),
        .alusel           (main_alusel),
        .reg1             (main_reg1),
        .reg2             (main_reg2),
        .wreg_addr        (main_wreg_addr),
        .wreg_enable      (main_wreg_enable)
    );

    pipe_slot #(
        .REG_W    (REG_W),
        .ADDR_W   (ADDR_W),
        .ALUOP_W  (ALUOP_W),
        .ALUSEL_W (ALUSEL_W)
    ) u_skid (
        .clk              (clk),
        .rst              (rst),
        .clear            (skid_clear),
        .load             (skid_load),
        .load_aluop       (id_aluop),
        .load_alusel      (id_alusel),
        .load_reg1        (id_reg1),
        .load_reg2        (id_reg2),
        .load_wreg_addr   (id_wreg_addr),
        .load_wreg_enable (id_wreg_enable),
        .valid            (skid_valid),
        .aluop            (skid_aluop),
        .alusel           (skid_alusel),
        .reg1             (skid_reg1),
        .reg2             (skid_reg2),
        .wreg_addr        (skid_wreg_addr),
        .wreg_enable      (skid_wreg_enable)
    );

    // EX payload: bubble whenever the main slot is empty
    always_comb begin
        ex_aluop       = ALUOP_W'(EXE_NOP_OP);
        ex_alusel      = ALUSEL_W'(EXE_RES_NOP);
        ex_reg1        = REG_W'(ZeroWord);
        ex_reg2        = REG_W'(ZeroWord);
        ex_wreg_addr   = ADDR_W'(NOPRegAddr);
        ex_wreg_enable = WriteDisable;
        if (main_valid) begin
            ex_aluop       = main_aluop;
            ex_alusel      = main_alusel;
            ex_reg1        = main_reg1;
            ex_reg2        = main_reg2;
            ex_wreg_addr   = main_wreg_addr;
            ex_wreg_enable = main_wreg_enable;
        end
    end

    always_comb begin
        unique case (state)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have parameters REG_W = 32 (operand width), ADDR_W = 5 (register address width), ALUOP_W = 8 (ALU op width) and ALUSEL_W = 3 (ALU select width).
REQ-002 The block SHALL use one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-003 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all held entries.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  block can accept this cycle.
- id_aluop  in  ALUOP_W  ALU operation.
- id_alusel  in  ALUSEL_W  ALU result select.
- id_reg1  in  REG_W  operand 1.
- id_reg2  in  REG_W  operand 2.
- id_wreg_addr  in  ADDR_W  destination register.
- id_wreg_enable  in  1  write-back request.
- ex_valid  out  1  EX payload valid.
- ex_ready  in  1  EX consumes this cycle.
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg_addr, ex_wreg_enable  out  same widths as id_*  payload to EX.
- occupancy  out  2  entries held (0..2).

Function
REQ-004 The block SHALL be a 2-entry elastic pipeline register (main slot drives ex_*, skid slot behind it) with strict FIFO order.
REQ-005 A push SHALL occur when id_valid && id_ready on a rising edge; a pop SHALL occur when ex_valid && ex_ready on a rising edge.
REQ-006 The state SHALL be EMPTY, ONE or TWO, with occupancy = 0/1/2 and ex_valid = (state != EMPTY).
REQ-007 id_ready SHALL be registered: high in EMPTY and ONE, low in TWO, and never combinationally dependent on ex_ready.
REQ-008 State transitions SHALL be:
- EMPTY + push -> ONE, with payload into main.
- ONE + push only -> TWO, with payload into skid.
- ONE + pop only -> EMPTY.
- ONE + push + pop -> ONE, with main replaced by the incoming payload.
- TWO + pop -> ONE, with skid moved to main.
- Any other combination holds the current state.
REQ-009 Latency SHALL be 1 cycle: a payload pushed at edge N appears on ex_* with ex_valid = 1 after edge N when the block was EMPTY, or ONE with a simultaneous pop.
REQ-010 Sustained throughput SHALL be one instruction per cycle while ex_ready stays high.
REQ-011 When ex_valid = 0, ex_* SHALL carry the NOP bubble: aluop EXE_NOP_OP, alusel EXE_RES_NOP, reg1/reg2 ZeroWord, wreg_addr NOPRegAddr, wreg_enable WriteDisable.
REQ-012 ex_wreg_enable SHALL be asserted only while ex_valid = 1.
REQ-013 When ex_valid = 1 and ex_ready = 0, ex_* SHALL hold stable until the pop.
REQ-014 flush SHALL set the state to EMPTY on the next edge and discard both slots, overriding any simultaneous push or pop; the instruction offered that cycle is dropped.
REQ-015 Ownership of a dropped instruction SHALL be: the upstream retains responsibility for it unless id_ready was high, in which case it is lost intentionally.
REQ-016 id_ready SHALL be high in the cycle after a flush.
REQ-017 Payload values SHALL pass through bit-exact, with no width conversion.

Reset
REQ-018 On rst = 1 at a rising edge, the state SHALL become EMPTY, occupancy 0, ex_valid 0, id_ready 1, and ex_* SHALL take the NOP bubble values of REQ-011.
REQ-019 rst SHALL take priority over flush, push and pop.
REQ-020 A reset asserted mid-operation, including in state TWO, SHALL discard all entries in one cycle.

Structure
REQ-021 The NOP encodings (EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, WriteDisable), RstEnable and the default width constants SHALL live in the shared consts header, not in this module.
REQ-022 Each slot SHALL be one instance of the sub-module pipe_slot, which holds a valid bit plus the payload, with load and clear controls, parametrised by the same widths.
REQ-023 The state machine and slot steering SHALL reside in id_ex_pipe.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: assert rst 2 cycles, release -> occupancy 0, ex_valid 0, id_ready 1, ex_aluop = EXE_NOP_OP, ex_wreg_enable 0.
- Streaming: ex_ready held 1, push reg1 = 0x1,0x2,0x3,0x4 on consecutive cycles -> ex_reg1 shows 0x1..0x4 on the following consecutive cycles, occupancy never exceeds 1.
- Backpressure: ex_ready 0, push 0xA then 0xB -> occupancy 2, id_ready 0, ex_reg1 holds 0xA; raise ex_ready -> 0xA then 0xB pop in order, id_ready high the cycle after the first pop.
- Simultaneous push+pop in ONE: main = 0x5, push 0x6 with ex_ready 1 -> next cycle ex_reg1 = 0x6, occupancy 1.
- Flush in TWO with id_valid 1 -> next cycle occupancy 0, ex_valid 0, bubble outputs, offered instruction absent from EX.
- Reset while in TWO with a pop pending -> EMPTY next cycle, nothing popped after reset.
